usb_crc_encoder: RTL and testbench
==================================

Name: usb_crc_encoder

Overview:
Parametrised serial CRC encoder between the protocol handler (PH) and the bit-stuffer (BS).
- Accepts one parallel packet: PID plus payload.
- Streams it out LSB-first with a handshake, computing CRC over the payload bits only.
- Appends the complemented CRC, MSB-first.
- One instance type serves data packets (CRC16) and token packets (CRC5) through parameters; supports back-pressure and a done pulse.

Parameters:
- PID_BITS, 8, PID field width; sent first, excluded from CRC.
- PAYLOAD_BITS, 64, payload width (11 for tokens); must be >= 1.
- CRC_WIDTH, 16, CRC register width; legal values 5 or 16.
- POLY, 16'h8005, generator polynomial without the x^CRC_WIDTH term (CRC5 uses 5'b00101).

Ports:
- clock, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- pkt_ready, input, 1, PH offers pkt_in this cycle.
- pkt_in, input, PID_BITS+PAYLOAD_BITS, PID in bits [PID_BITS-1:0], payload above it.
- pkt_taken, output, 1, one-cycle pulse: packet captured.
- bs_ready, input, 1, BS accepts out_bit this cycle.
- out_bit, output, 1, current serial bit.
- crc_valid_out, output, 1, out_bit is valid.
- pkt_done, output, 1, one-cycle pulse on transfer of the final CRC bit.

Behaviour:
- Reset (async, any state, including mid-packet):
  - State goes to IDLE; shift and CRC registers clear.
  - All outputs go to 0.
  - A partial packet is abandoned; nothing resumes after reset.
- Bit transfer: occurs when crc_valid_out && bs_ready.
  - out_bit and crc_valid_out are registered and hold stable while bs_ready is low.
- IDLE:
  - If pkt_ready, capture pkt_in, pulse pkt_taken, and load the CRC register with all ones.
  - Next cycle: state = PID, crc_valid_out = 1, out_bit = pkt_in[0].
  - pkt_ready is ignored in every other state; pkt_taken stays 0 there.
- PID: send PID_BITS bits LSB-first; no CRC update. After the last PID transfer, go to DATA.
- DATA: send PAYLOAD_BITS bits LSB-first.
  - On each transfer of bit b: fb = crc[CRC_WIDTH-1] ^ b; crc = (crc << 1) ^ (fb ? POLY : 0), truncated to CRC_WIDTH.
  - After the last payload transfer, go to CRC.
- CRC: send ~crc, bit CRC_WIDTH-1 first, CRC_WIDTH bits.
  - On the final transfer: pkt_done = 1 for one cycle, crc_valid_out = 0 next cycle, state = IDLE.
- A new packet can be accepted in the cycle after pkt_done. Back-to-back packets therefore have exactly one idle cycle of bubble.
- Total transfers per packet: PID_BITS + PAYLOAD_BITS + CRC_WIDTH (88 for the defaults).
- Bit counter: width $clog2(max(PID_BITS, PAYLOAD_BITS, CRC_WIDTH)+1); resets to 0 on each state change.
- Elaboration fails if CRC_WIDTH is not in {5, 16}.

Optional Feature:
Macro: USB_CRC_VARLEN_EN.
- Defined:
  - Adds input pkt_len [$clog2(PAYLOAD_BITS/8+1)-1:0], a byte count captured together with pkt_in.
  - DATA sends only pkt_len*8 payload bits.
  - pkt_len == 0 goes directly PID -> CRC; this is a zero-length packet and the CRC field is 16'h0000.
  - pkt_len > PAYLOAD_BITS/8 is clamped to the maximum.
  - PAYLOAD_BITS must be a multiple of 8.
- Undefined: the port is absent and the full PAYLOAD_BITS are always sent.

Decomposition:
- Package usb_crc_pkg holds:
  - CRC16_POLY = 16'h8005 and CRC5_POLY = 5'h05.
  - CRC16_RESIDUE = 16'h800D and CRC5_RESIDUE = 5'h0C, for the checker.
  - enum enc_state_t {IDLE, PID, DATA, CRC}.
- Sub-module crc_lfsr_step, parametrised by CRC_WIDTH and POLY: combinational one-bit next-CRC function. It will be reused by the future decoder.

Test Plan:
1. Defaults, pkt_in = 72'h0f21000000000000_C3, bs_ready held 1:
   - pkt_taken pulses once.
   - 88 bits are sent: C3 LSB-first, then the payload, then the CRC field 16'ha0e7.
   - pkt_done falls on bit 88.
2. Same, pkt_in = 72'h40aa11b7682df6d8_C3 -> CRC field 16'h544a.
3. Case 1 with bs_ready toggled pseudo-randomly:
   - Identical 88-bit sequence.
   - out_bit stable whenever bs_ready is low.
   - pkt_ready during the packet is ignored.
4. Assert reset at transfer 40, then offer a new packet: outputs go to 0 immediately; the new packet is sent complete and correct.
5. CRC_WIDTH=5, POLY=5'h05, PAYLOAD_BITS=11, PID 8'hE1:
   - Feeding the payload plus CRC field into crc_lfsr_step leaves residue 5'h0C.
6. USB_CRC_VARLEN_EN defined, pkt_len = 0:
   - 24 bits sent: the PID, then 16'h0000.
   - pkt_done on bit 24; a second packet is accepted one cycle later.

Source files
------------

// File: rtl/usb_crc_pkg.sv
// usb_crc_pkg: shared definitions for the USB serial CRC encoder and decoder.
//   - Generator polynomials, without the x^N term.
//   - Good-packet residues that a receiver's CRC register holds after it has
//     consumed the payload plus the transmitted CRC field.
//   - Encoder state type and a small constant helper.
package usb_crc_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h8005;
  localparam logic [4:0]  CRC5_POLY     = 5'h05;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;
  localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PID  = 2'd1,
    DATA = 2'd2,
    CRC  = 2'd3
  } enc_state_t;

  // Largest of three sizes. Used to width the per-field bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usb_crc_encoder_lfsr_step.sv
// crc_lfsr_step: one serial step of an MSB-first CRC register. Purely
// combinational, so the decoder can reuse it.
//   crc_in  : current CRC register value
//   bit_in  : data bit being absorbed
//   crc_out : register value after absorbing bit_in
// Parameters: CRC_WIDTH (register width), POLY (generator without x^CRC_WIDTH).
module crc_lfsr_step #(
  parameter int                   CRC_WIDTH = 16,
  parameter logic [CRC_WIDTH-1:0] POLY      = 16'h8005
) (
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic                 bit_in,
  output logic [CRC_WIDTH-1:0] crc_out
);

  logic fb;

  assign fb = crc_in[CRC_WIDTH-1] ^ bit_in;

  // Shift left by one and fold the feedback into the tapped positions.
  assign crc_out[0] = fb & POLY[0];
  for (genvar gi = 1; gi < CRC_WIDTH; gi++) begin : g_bit
    assign crc_out[gi] = crc_in[gi-1] ^ (fb & POLY[gi]);
  end

endmodule

// File: rtl/usb_crc_encoder.sv
// usb_crc_encoder: serialises one parallel packet from the protocol handler.
// The order on the wire is:
//   1. the PID, LSB-first;
//   2. the payload, LSB-first;
//   3. the complemented CRC of the payload, MSB-first.
// Data and token packets use the same module with different parameters
// (CRC16 with a 64-bit payload, or CRC5 with an 11-bit payload).
//
// Ports:
//   clock, reset   : rising-edge clock, asynchronous active-high reset
//   pkt_ready      : protocol handler offers pkt_in (sampled only in IDLE)
//   pkt_in         : {payload, pid}, with the PID in the low PID_BITS bits
//   pkt_len        : payload byte count (only with USB_CRC_VARLEN_EN)
//   pkt_taken      : one-cycle pulse when the packet is captured
//   bs_ready       : bit-stuffer accepts out_bit this cycle
//   out_bit        : current serial bit (held while bs_ready is low)
//   crc_valid_out  : out_bit is valid
//   pkt_done       : one-cycle pulse after the last CRC bit is transferred
//
// Optional build macro USB_CRC_VARLEN_EN:
//   - adds pkt_len, so only pkt_len*8 payload bits are sent;
//   - pkt_len is clamped to PAYLOAD_BITS/8;
//   - pkt_len == 0 goes straight from PID to CRC, which gives a 0000 CRC field.
module usb_crc_encoder
  import usb_crc_pkg::*;
#(
  parameter int                   PID_BITS     = 8,
  parameter int                   PAYLOAD_BITS = 64,
  parameter int                   CRC_WIDTH    = 16,
  parameter logic [CRC_WIDTH-1:0] POLY         = CRC_WIDTH'(CRC16_POLY)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             pkt_ready,
  input  logic [PID_BITS+PAYLOAD_BITS-1:0] pkt_in,
`ifdef USB_CRC_VARLEN_EN
  input  logic [$clog2(PAYLOAD_BITS/8+1)-1:0] pkt_len,
`endif
  output logic                             pkt_taken,
  input  logic                             bs_ready,
  output logic                             out_bit,
  output logic                             crc_valid_out,
  output logic                             pkt_done
);

  localparam int PKT_BITS = PID_BITS + PAYLOAD_BITS;
  localparam int CNT_W    = $clog2(max3(PID_BITS, PAYLOAD_BITS, CRC_WIDTH) + 1);

  localparam logic [CNT_W-1:0] PID_LAST  = CNT_W'(PID_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_WIDTH - 1);

  if (!(CRC_WIDTH == 5 || CRC_WIDTH == 16)) begin : g_bad_crc_width
    $error("usb_crc_encoder: CRC_WIDTH must be 5 or 16");
  end
  if (PAYLOAD_BITS < 1) begin : g_bad_payload
    $error("usb_crc_encoder: PAYLOAD_BITS must be at least 1");
  end

  enc_state_t           state_reg;
  logic [PKT_BITS-1:0]  shift_reg;
  logic [CRC_WIDTH-1:0] crc_reg;
  logic [CRC_WIDTH-1:0] crc_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 out_bit_reg;
  logic                 valid_reg;
  logic                 taken_reg;
  logic                 done_reg;
  logic                 xfer;
  logic [CNT_W-1:0]     data_last;
  logic                 has_data;

`ifdef USB_CRC_VARLEN_EN
  localparam int MAX_BYTES = PAYLOAD_BITS / 8;

  if (PAYLOAD_BITS % 8 != 0) begin : g_bad_varlen
    $error("usb_crc_encoder: PAYLOAD_BITS must be a multiple of 8 with variable length");
  end

  logic [CNT_W-1:0] len_bits;
  logic [CNT_W-1:0] data_bits_reg;

  always_comb begin
    len_bits = CNT_W'(PAYLOAD_BITS);
    if (int'(pkt_len) <= MAX_BYTES) begin
      len_bits = CNT_W'(int'(pkt_len) * 8);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_bits_reg <= '0;
    end else if (state_reg == IDLE && pkt_ready) begin
      data_bits_reg <= len_bits;
    end
  end

  assign data_last = data_bits_reg - CNT_W'(1);
  assign has_data  = (data_bits_reg != '0);
`else
  assign data_last = DATA_LAST;
  assign has_data  = 1'b1;
`endif

  // The bit on the wire is the one that updates the CRC.
  crc_lfsr_step #(
    .CRC_WIDTH (CRC_WIDTH),
    .POLY      (POLY)
  ) u_step (
    .crc_in  (crc_reg),
    .bit_in  (out_bit_reg),
    .crc_out (crc_next)
  );

  assign xfer = valid_reg & bs_ready;

  // shift_reg[0] is always the bit on the wire. The next bit to present is
  // therefore shift_reg[1], in both the PID phase and the payload phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      crc_reg     <= '0;
      cnt_reg     <= '0;
      out_bit_reg <= 1'b0;
      valid_reg   <= 1'b0;
      taken_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      taken_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pkt_ready) begin
            shift_reg   <= pkt_in;
            crc_reg     <= '1;
            cnt_reg     <= '0;
            taken_reg   <= 1'b1;
            valid_reg   <= 1'b1;
            out_bit_reg <= pkt_in[0];
            state_reg   <= PID;
          end
        end
        PID: begin
          if (xfer) begin
            shift_reg <= shift_reg >> 1;
            if (cnt_reg == PID_LAST) begin
              cnt_reg <= '0;
              if (has_data) begin
                state_reg   <= DATA;
                out_bit_reg <= shift_reg[1];
              end else begin
                // Zero-length payload: the CRC is still all ones, so the
                // field goes out as zeros.
                state_reg   <= CRC;
                out_bit_reg <= ~crc_reg[CRC_WIDTH-1];
              end
            end else begin
              cnt_reg     <= cnt_reg + CNT_W'(1);
              out_bit_reg <= shift_reg[1];
            end
          end
        end
        DATA: begin
          if (xfer) begin
            shift_reg <= shift_reg >> 1;
            crc_reg   <= crc_next;
            if (cnt_reg == data_last) begin
              cnt_reg     <= '0;
              state_reg   <= CRC;
              out_bit_reg <= ~crc_next[CRC_WIDTH-1];
            end else begin
              cnt_reg     <= cnt_reg + CNT_W'(1);
              out_bit_reg <= shift_reg[1];
            end
          end
        end
        CRC: begin
          if (xfer) begin
            // Shift the CRC up so that its next MSB is always in bit CRC_WIDTH-1.
            crc_reg <= crc_reg << 1;
            if (cnt_reg == CRC_LAST) begin
              cnt_reg     <= '0;
              state_reg   <= IDLE;
              valid_reg   <= 1'b0;
              done_reg    <= 1'b1;
              out_bit_reg <= 1'b0;
            end else begin
              cnt_reg     <= cnt_reg + CNT_W'(1);
              out_bit_reg <= ~crc_reg[CRC_WIDTH-2];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_bit       = out_bit_reg;
  assign crc_valid_out = valid_reg;
  assign pkt_taken     = taken_reg;
  assign pkt_done      = done_reg;

endmodule

// File: tb/tb_usb_crc_encoder.sv
// tb_usb_crc_encoder: directed, table-driven bench for usb_crc_encoder.
// The main instance uses the default CRC16 data-packet parameters. A CRC5
// token instance is present only when USB_CRC_VARLEN_EN is not defined.
// Expected CRC fields are written LSB-first in transmission order, which is
// the usual USB notation. The bench also computes them with a reflected CRC
// model.
module tb_usb_crc_encoder;
  import usb_crc_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_ready = 1'b0;
  logic [71:0] pkt_in = '0;
  logic        pkt_taken;
  logic        bs_ready = 1'b0;
  logic        out_bit;
  logic        crc_valid_out;
  logic        pkt_done;
`ifdef USB_CRC_VARLEN_EN
  logic [3:0]  pkt_len = 4'd8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  usb_crc_encoder u_dut (
    .clock         (clock),
    .reset         (reset),
    .pkt_ready     (pkt_ready),
    .pkt_in        (pkt_in),
`ifdef USB_CRC_VARLEN_EN
    .pkt_len       (pkt_len),
`endif
    .pkt_taken     (pkt_taken),
    .bs_ready      (bs_ready),
    .out_bit       (out_bit),
    .crc_valid_out (crc_valid_out),
    .pkt_done      (pkt_done)
  );

`ifndef USB_CRC_VARLEN_EN
  logic        tok_ready = 1'b0;
  logic [18:0] tok_in = '0;
  logic        tok_taken;
  logic        tok_bs_ready = 1'b0;
  logic        tok_bit;
  logic        tok_valid;
  logic        tok_done;

  usb_crc_encoder #(
    .PID_BITS     (8),
    .PAYLOAD_BITS (11),
    .CRC_WIDTH    (5),
    .POLY         (CRC5_POLY)
  ) u_tok (
    .clock         (clock),
    .reset         (reset),
    .pkt_ready     (tok_ready),
    .pkt_in        (tok_in),
    .pkt_taken     (tok_taken),
    .bs_ready      (tok_bs_ready),
    .out_bit       (tok_bit),
    .crc_valid_out (tok_valid),
    .pkt_done      (tok_done)
  );
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reflected USB CRC16 (poly A001, init FFFF). Returns the complemented
  // field, whose bit 0 goes on the wire first.
  function automatic logic [15:0] usb_crc16_field(input logic [63:0] pl);
    logic [15:0] q;
    q = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      if (q[0] ^ pl[i]) q = (q >> 1) ^ 16'hA001;
      else              q = q >> 1;
    end
    return ~q;
  endfunction

  function automatic logic [4:0] usb_crc5_field(input logic [10:0] pl);
    logic [4:0] q;
    q = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (q[0] ^ pl[i]) q = (q >> 1) ^ 5'h14;
      else              q = q >> 1;
    end
    return ~q;
  endfunction

  // Receiver-side check: run bits [first, last) through a w-bit MSB-first
  // register, starting from all ones.
  function automatic logic [15:0] residue(input logic [127:0] bits, input int first,
                                          input int last, input int w,
                                          input logic [15:0] poly);
    logic [15:0] c;
    logic [15:0] mask;
    logic        fb;
    mask = 16'((32'd1 << w) - 1);
    c = mask;
    for (int i = first; i < last; i++) begin
      fb = c[w-1] ^ bits[i];
      c  = ((c << 1) ^ (fb ? poly : 16'h0)) & mask;
    end
    return c;
  endfunction

  // Offer one packet, then collect every transferred bit until pkt_done.
  task automatic send_pkt(input logic [71:0] pkt, input logic [3:0] len, input bit rnd,
                          input bit poke, output int n, output logic [127:0] rx,
                          output int n_taken, output int first_taken, output int done_at,
                          output int unstable, output logic valid_after_done);
    bit   started;
    logic pre_valid, pre_bit, pre_ready;
    started = 1'b0;
    n = 0; rx = '0; n_taken = 0; first_taken = -1; done_at = -1; unstable = 0;
    valid_after_done = 1'b1;
    @(negedge clock);
    pkt_ready = 1'b1;
    pkt_in    = pkt;
`ifdef USB_CRC_VARLEN_EN
    pkt_len   = len;
`else
    if (len == 4'hF) pkt_in = pkt;
`endif
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge clock);
      bs_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (started) pkt_ready = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      pre_valid = crc_valid_out;
      pre_bit   = out_bit;
      pre_ready = bs_ready;
      @(posedge clock);
      #1;
      if (pkt_taken) begin
        n_taken++;
        if (first_taken < 0) first_taken = cyc;
        started = 1'b1;
      end
      if (pre_valid && pre_ready) begin
        if (n < 128) rx[n] = pre_bit;
        n++;
      end else if (pre_valid && crc_valid_out && out_bit !== pre_bit) begin
        unstable++;
      end
      if (pkt_done) begin
        done_at = n;
        valid_after_done = crc_valid_out;
        break;
      end
    end
    pkt_ready = 1'b0;
  endtask

`ifndef USB_CRC_VARLEN_EN
  task automatic send_tok(input logic [10:0] pl, output int n, output logic [127:0] rx,
                          output int done_at);
    logic pre_valid, pre_bit;
    n = 0; rx = '0; done_at = -1;
    @(negedge clock);
    tok_ready    = 1'b1;
    tok_in       = {pl, 8'hE1};
    tok_bs_ready = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc > 0) @(negedge clock);
      pre_valid = tok_valid;
      pre_bit   = tok_bit;
      @(posedge clock);
      #1;
      if (tok_taken) tok_ready = 1'b0;
      if (pre_valid) begin
        rx[n] = pre_bit;
        n++;
      end
      if (tok_done) begin
        done_at = n;
        break;
      end
    end
    tok_ready = 1'b0;
  endtask
`endif

  typedef struct {
    string       name;
    logic [71:0] pkt;
    logic [15:0] field;
    bit          rnd;
    bit          poke;
  } vec_t;

  initial begin
    vec_t        vecs[4];
    int          n, n_taken, first_taken, done_at, unstable;
    logic        vad;
    logic [127:0] rx;

    vecs[0] = '{"data_zero_tail", 72'h0f21000000000000_C3, 16'ha0e7, 1'b0, 1'b0};
    vecs[1] = '{"data_mixed",     72'h40aa11b7682df6d8_C3, 16'h544a, 1'b0, 1'b0};
    vecs[2] = '{"data_backpress", 72'h0f21000000000000_C3, 16'ha0e7, 1'b1, 1'b1};
    vecs[3] = '{"data_all_ones",  {64'hFFFF_FFFF_FFFF_FFFF, 8'h4B},
                usb_crc16_field(64'hFFFF_FFFF_FFFF_FFFF), 1'b1, 1'b0};

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {60'h0, out_bit, crc_valid_out, pkt_taken, pkt_done}, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle_outputs", {60'h0, out_bit, crc_valid_out, pkt_taken, pkt_done}, 64'h0);

    for (int v = 0; v < 4; v++) begin
      send_pkt(vecs[v].pkt, 4'd8, vecs[v].rnd, vecs[v].poke, n, rx, n_taken, first_taken,
               done_at, unstable, vad);
      check({vecs[v].name, "_taken_once"}, 64'(n_taken), 64'd1);
      check({vecs[v].name, "_accept_latency"}, 64'(first_taken), 64'd0);
      check({vecs[v].name, "_bit_count"}, 64'(n), 64'd88);
      check({vecs[v].name, "_done_at"}, 64'(done_at), 64'd88);
      check({vecs[v].name, "_valid_after_done"}, {63'h0, vad}, 64'h0);
      check({vecs[v].name, "_pid"}, {56'h0, rx[7:0]}, {56'h0, vecs[v].pkt[7:0]});
      check({vecs[v].name, "_payload"}, rx[71:8], vecs[v].pkt[71:8]);
      check({vecs[v].name, "_crc_field"}, {48'h0, rx[87:72]}, {48'h0, vecs[v].field});
      check({vecs[v].name, "_residue"}, {48'h0, residue(rx, 8, 88, 16, CRC16_POLY)},
            {48'h0, CRC16_RESIDUE});
      check({vecs[v].name, "_stable"}, 64'(unstable), 64'd0);
      $display("packet %s: %0d bits, crc field %h", vecs[v].name, n, rx[87:72]);
    end

    // Reset in the middle of a packet, then a fresh packet.
    @(negedge clock);
    pkt_ready = 1'b1;
    pkt_in    = vecs[1].pkt;
    bs_ready  = 1'b1;
    @(posedge clock);
    #1;
    pkt_ready = 1'b0;
    repeat (40) @(posedge clock);
    #3;
    check("midpkt_valid_before_reset", {63'h0, crc_valid_out}, 64'h1);
    reset = 1'b1;
    #1;
    check("midpkt_reset_outputs", {60'h0, out_bit, crc_valid_out, pkt_taken, pkt_done}, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("midpkt_no_resume", {62'h0, crc_valid_out, pkt_done}, 64'h0);
    send_pkt(vecs[0].pkt, 4'd8, 1'b0, 1'b0, n, rx, n_taken, first_taken, done_at, unstable, vad);
    check("after_reset_bit_count", 64'(n), 64'd88);
    check("after_reset_payload", rx[71:8], vecs[0].pkt[71:8]);
    check("after_reset_crc_field", {48'h0, rx[87:72]}, 64'ha0e7);
    $display("packet after_reset: %0d bits, crc field %h", n, rx[87:72]);

`ifndef USB_CRC_VARLEN_EN
    // CRC5 token packets.
    for (int t = 0; t < 2; t++) begin
      logic [10:0] pl;
      logic [4:0]  exp_field;
      pl        = (t == 0) ? 11'h000 : 11'h3A5;
      exp_field = (t == 0) ? 5'h02 : usb_crc5_field(11'h3A5);
      send_tok(pl, n, rx, done_at);
      check("tok_bit_count", 64'(n), 64'd24);
      check("tok_done_at", 64'(done_at), 64'd24);
      check("tok_pid", {56'h0, rx[7:0]}, 64'hE1);
      check("tok_payload", {53'h0, rx[18:8]}, {53'h0, pl});
      check("tok_crc_field", {59'h0, rx[23:19]}, {59'h0, exp_field});
      check("tok_residue", {48'h0, residue(rx, 8, 24, 5, 16'(CRC5_POLY))},
            {48'h0, 11'h0, CRC5_RESIDUE});
      $display("token payload %h: %0d bits, crc5 field %h", pl, n, rx[23:19]);
    end
`else
    // Zero-length packet followed immediately by a one-byte packet.
    send_pkt({64'h1234_5678_9abc_def0, 8'hC3}, 4'd0, 1'b0, 1'b0, n, rx, n_taken,
             first_taken, done_at, unstable, vad);
    check("zlp_bit_count", 64'(n), 64'd24);
    check("zlp_done_at", 64'(done_at), 64'd24);
    check("zlp_pid", {56'h0, rx[7:0]}, 64'hC3);
    check("zlp_crc_field", {48'h0, rx[23:8]}, 64'h0);
    $display("packet zlp: %0d bits, crc field %h", n, rx[23:8]);
    pkt_ready = 1'b1;
    pkt_in    = {56'h0, 8'h5A, 8'hC3};
    pkt_len   = 4'd1;
    @(posedge clock);
    #1;
    check("zlp_next_taken", {63'h0, pkt_taken}, 64'h1);
    pkt_ready = 1'b0;
    n = 0; rx = '0; done_at = -1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      logic pv, pb;
      @(negedge clock);
      pv = crc_valid_out;
      pb = out_bit;
      @(posedge clock);
      #1;
      if (pv) begin
        rx[n] = pb;
        n++;
      end
      if (pkt_done) begin
        done_at = n;
        break;
      end
    end
    check("len1_bit_count", 64'(done_at), 64'd32);
    check("len1_payload", {56'h0, rx[15:8]}, 64'h5A);
    check("len1_residue", {48'h0, residue(rx, 8, 32, 16, CRC16_POLY)}, {48'h0, CRC16_RESIDUE});
    $display("packet len1: %0d bits, crc field %h", n, rx[31:16]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
